// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
// FSM state enum, load fun3 codes, store byte masks, alignment helper.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    // Size comes from the store mask for stores and
    // from fun3[1:0] for loads; byte never misaligns.
    function automatic logic misaligned(
        input logic       is_store,
        input logic [1:0] ld_sz,
        input logic [3:0] st_mask,
        input logic [1:0] lo
    );
        logic w_half;
        logic w_word;
        if (is_store) begin
            w_half = (st_mask == MASK_H);
            w_word = (st_mask == MASK_W);
        end else begin
            w_half = (ld_sz == 2'b01);
            w_word = (ld_sz == 2'b10);
        end
        return (w_half & lo[0]) |
               (w_word & (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane logic for the load/store unit.
// Ports: i_st_* store mask/offset/data -> o_st_strb, o_st_data;
//        i_ld_* raw word/offset/fun3 -> o_ld_data (aligned, extended).
module lsu_align
    import lsu_pkg::*;
(
    input  logic [3:0]  i_st_mask,
    input  logic [1:0]  i_st_lo,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_strb,
    output logic [31:0] o_st_data,
    input  logic [31:0] i_ld_raw,
    input  logic [1:0]  i_ld_lo,
    input  logic [2:0]  i_ld_f3,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_ld_sh;

    assign o_st_strb = i_st_mask << i_st_lo;
    assign w_ld_sh   = i_ld_raw >> {i_ld_lo, 3'b000};

    // Replicate the low lanes so the strobe picks
    // the right copy regardless of offset.
    always_comb begin
        o_st_data = i_st_data;
        unique case (i_st_mask)
            MASK_B:  o_st_data = {4{i_st_data[7:0]}};
            MASK_H:  o_st_data = {2{i_st_data[15:0]}};
            default: o_st_data = i_st_data;
        endcase
    end

    always_comb begin
        o_ld_data = '0;
        unique case (i_ld_f3)
            F3_LB:   o_ld_data = {{24{w_ld_sh[7]}},
                                  w_ld_sh[7:0]};
            F3_LH:   o_ld_data = {{16{w_ld_sh[15]}},
                                  w_ld_sh[15:0]};
            F3_LW:   o_ld_data = w_ld_sh;
            F3_LBU:  o_ld_data = {24'd0, w_ld_sh[7:0]};
            F3_LHU:  o_ld_data = {16'd0, w_ld_sh[15:0]};
            default: o_ld_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller (IDLE -> REQ -> DONE) with
// misalign detection, bus timeout and load extract/extend.
// Ports: clk, rst (sync, active-high); mem_rd/mem_we, data_mem_opr,
//   data_mem_opw, addr, wdata from the core; stall, rdata, misalign,
//   bus_err to the core; bus_req/we/addr/wstrb/wdata, bus_ack/rdata.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_we,
    input  logic [2:0]  data_mem_opr,
    input  logic [3:0]  data_mem_opw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    lsu_state_e  r_state;
    lsu_state_e  w_next;

    logic [7:0]  r_cnt;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_wstrb;
    logic        r_bus_we;
    logic [1:0]  r_lo;
    logic [2:0]  r_opr;
    logic [31:0] r_rdata;
    logic        r_bus_err;

    logic        w_access;
    logic        w_store;
    logic        w_misal;
    logic        w_stall;
    logic        w_misalign;
    logic        w_start;
    logic        w_ack_hit;
    logic        w_timeout;
    logic [3:0]  w_st_strb;
    logic [31:0] w_st_data;
    logic [31:0] w_ld_data;

    // A store wins when both requests are raised.
    assign w_access = mem_rd | mem_we;
    assign w_store  = mem_we;
    assign w_misal  = misaligned(w_store,
                                 data_mem_opr[1:0],
                                 data_mem_opw,
                                 addr[1:0]);

    lsu_align u_align (
        .i_st_mask (data_mem_opw),
        .i_st_lo   (addr[1:0]),
        .i_st_data (wdata),
        .o_st_strb (w_st_strb),
        .o_st_data (w_st_data),
        .i_ld_raw  (bus_rdata),
        .i_ld_lo   (r_lo),
        .i_ld_f3   (r_opr),
        .o_ld_data (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Ack is checked before the timeout so a
    // last-cycle ack still completes normally.
    always_comb begin
        w_next     = r_state;
        w_stall    = 1'b0;
        w_misalign = 1'b0;
        w_start    = 1'b0;
        w_ack_hit  = 1'b0;
        w_timeout  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_access) begin
                    if (w_misal) begin
                        w_misalign = 1'b1;
                    end else begin
                        w_stall = 1'b1;
                        w_start = 1'b1;
                        w_next  = REQ;
                    end
                end
            end
            REQ: begin
                w_stall = 1'b1;
                if (bus_ack) begin
                    w_ack_hit = 1'b1;
                    w_next    = DONE;
                end else if (r_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wstrb <= '0;
            r_bus_we    <= 1'b0;
            r_lo        <= '0;
            r_opr       <= '0;
            r_rdata     <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_bus_err <= w_timeout;
            if (w_start) begin
                r_cnt       <= '0;
                r_bus_addr  <= {addr[31:2], 2'b00};
                r_bus_we    <= w_store;
                r_bus_wstrb <= w_store ? w_st_strb : 4'b0;
                r_bus_wdata <= w_store ? w_st_data : '0;
                r_lo        <= addr[1:0];
                r_opr       <= data_mem_opr;
            end else if (r_state == REQ && !bus_ack) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_ack_hit && !r_bus_we) begin
                r_rdata <= w_ld_data;
            end else if (w_timeout) begin
                r_rdata <= '0;
            end
        end
    end

    // Reset masks the combinational handshakes too.
    assign stall     = w_stall & ~rst;
    assign misalign  = w_misalign & ~rst;
    assign bus_req   = (r_state == REQ);
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wstrb = r_bus_wstrb;
    assign bus_wdata = r_bus_wdata;
    assign rdata     = r_rdata;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl (TIMEOUT=4).
// Scenario tasks with a queue scoreboard of bus and rdata expectations.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_rd = 1'b0;
    logic        mem_we = 1'b0;
    logic [2:0]  data_mem_opr = '0;
    logic [3:0]  data_mem_opw = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_exp_t;

    bus_exp_t    bus_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] exp_rdata = '0;

    lsu_ctrl #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rd       (mem_rd),
        .mem_we       (mem_we),
        .data_mem_opr (data_mem_opr),
        .data_mem_opw (data_mem_opw),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .rdata        (rdata),
        .misalign     (misalign),
        .bus_err      (bus_err),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wstrb    (bus_wstrb),
        .bus_wdata    (bus_wdata),
        .bus_ack      (bus_ack),
        .bus_rdata    (bus_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input logic rd, input logic we,
                           input logic [2:0] opr,
                           input logic [3:0] opw,
                           input logic [31:0] a,
                           input logic [31:0] wd);
        mem_rd = rd;
        mem_we = we;
        data_mem_opr = opr;
        data_mem_opw = opw;
        addr = a;
        wdata = wd;
    endtask

    task automatic clr_req();
        set_req(1'b0, 1'b0, 3'b0, 4'b0, 32'h0, 32'h0);
    endtask

    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            if (bus_req) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_ack = 1'b1;
        set_req(1'b1, 1'b0, 3'b010, 4'b0, 32'h40, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({stall, misalign, bus_req, bus_err} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_ctl: got %b want 0000",
                     {stall, misalign, bus_req, bus_err});
        end
        n_checks++;
        if ({bus_we, bus_wstrb} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_we_strb: got %b want 0",
                     {bus_we, bus_wstrb});
        end
        n_checks++;
        if ({bus_addr, bus_wdata, rdata} !== 96'b0) begin
            n_fail++;
            $display("FAIL rst_data: got %h %h %h want 0",
                     bus_addr, bus_wdata, rdata);
        end
        addr = 32'h41;
        #1;
        n_checks++;
        if (misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_misal: got %b want 0", misalign);
        end
        @(negedge clk);
        rst = 1'b0;
        bus_ack = 1'b0;
        clr_req();
        #1;
        n_checks++;
        if ({stall, bus_req} !== 2'b0) begin
            n_fail++;
            $display("FAIL rst_rel: got %b want 00",
                     {stall, bus_req});
        end
    endtask

    task automatic test_lb();
        bus_exp_t e;
        bit ok;
        int stalls = 0;
        @(negedge clk);
        set_req(1'b1, 1'b0, 3'b000, 4'b0, 32'h103, 32'h0);
        bus_q.push_back('{32'h100, 1'b0, 4'b0, 32'h0});
        exp_rdata = 32'hFFFFFF80;
        rd_q.push_back(exp_rdata);
        #1;
        if (stall) stalls++;
        n_checks++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL lb_stall0: got %b want 1", stall);
        end
        wait_req(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL lb_req: got no bus_req want bus_req");
        end
        if (stall) stalls++;
        e = bus_q.pop_front();
        n_checks++;
        if ({bus_addr, bus_we, bus_wstrb} !==
            {e.addr, e.we, e.wstrb}) begin
            n_fail++;
            $display("FAIL lb_bus: got %h %b %b want %h %b %b",
                     bus_addr, bus_we, bus_wstrb,
                     e.addr, e.we, e.wstrb);
        end
        bus_ack = 1'b1;
        bus_rdata = 32'h80FFFFFF;
        @(negedge clk);
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        #1;
        if (stall) stalls++;
        n_checks++;
        if (stalls != 2) begin
            n_fail++;
            $display("FAIL lb_stall_cyc: got %0d want 2", stalls);
        end
        n_checks++;
        if (rdata !== rd_q[0]) begin
            n_fail++;
            $display("FAIL lb_rdata: got %h want %h",
                     rdata, rd_q[0]);
        end
        void'(rd_q.pop_front());
        @(negedge clk);
        clr_req();
        #1;
        n_checks++;
        if ({bus_req, stall} !== 2'b0 || rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL lb_done_ign: got %b %h want 00 %h",
                     {bus_req, stall}, rdata, exp_rdata);
        end
    endtask

    task automatic test_sh();
        bus_exp_t e;
        bit ok;
        @(negedge clk);
        set_req(1'b0, 1'b1, 3'b0, 4'b0011, 32'h202, 32'h1234ABCD);
        bus_q.push_back('{32'h200, 1'b1, 4'b1100, 32'hABCDABCD});
        rd_q.push_back(exp_rdata);
        #1;
        wait_req(ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sh_req: got no bus_req want bus_req");
        end
        clr_req();
        e = bus_q.pop_front();
        n_checks++;
        if ({bus_addr, bus_we, bus_wstrb, bus_wdata} !==
            {e.addr, e.we, e.wstrb, e.wdata}) begin
            n_fail++;
            $display("FAIL sh_bus: got %h %b %b %h want %h %b %b %h",
                     bus_addr, bus_we, bus_wstrb, bus_wdata,
                     e.addr, e.we, e.wstrb, e.wdata);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus_req, stall, bus_addr, bus_we, bus_wstrb, bus_wdata}
            !== {2'b11, e.addr, e.we, e.wstrb, e.wdata}) begin
            n_fail++;
            $display("FAIL sh_hold: got %b %h %b %b %h",
                     {bus_req, stall}, bus_addr, bus_we,
                     bus_wstrb, bus_wdata);
        end
        bus_ack = 1'b1;
        bus_rdata = 32'hDEADBEEF;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        n_checks++;
        if ({stall, bus_req} !== 2'b0 || rdata !== rd_q[0]) begin
            n_fail++;
            $display("FAIL sh_rdata: got %b %h want 00 %h",
                     {stall, bus_req}, rdata, rd_q[0]);
        end
        void'(rd_q.pop_front());
    endtask

    task automatic test_misalign();
        bit seen = 1'b0;
        @(negedge clk);
        set_req(1'b1, 1'b0, 3'b010, 4'b0, 32'h105, 32'h0);
        #1;
        n_checks++;
        if ({misalign, stall, bus_req} !== 3'b100) begin
            n_fail++;
            $display("FAIL lw_misal: got %b want 100",
                     {misalign, stall, bus_req});
        end
        @(negedge clk);
        clr_req();
        #1;
        n_checks++;
        if (misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL misal_pulse: got %b want 0", misalign);
        end
        set_req(1'b0, 1'b1, 3'b0, 4'b0011, 32'h201, 32'h55);
        #1;
        n_checks++;
        if ({misalign, stall} !== 2'b10) begin
            n_fail++;
            $display("FAIL sh_misal: got %b want 10",
                     {misalign, stall});
        end
        if (bus_req) seen = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            clr_req();
            #1;
            if (bus_req) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_fail++;
            $display("FAIL misal_noreq: got bus_req want none");
        end
    endtask

    task automatic test_timeout();
        bus_exp_t e;
        bit ok;
        int cyc = 1;
        @(negedge clk);
        set_req(1'b1, 1'b0, 3'b010, 4'b0, 32'h300, 32'h0);
        bus_q.push_back('{32'h300, 1'b0, 4'b0, 32'h0});
        exp_rdata = 32'h0;
        rd_q.push_back(exp_rdata);
        #1;
        wait_req(ok);
        clr_req();
        e = bus_q.pop_front();
        n_checks++;
        if (!ok || bus_addr !== e.addr) begin
            n_fail++;
            $display("FAIL to_req: got %b %h want 1 %h",
                     ok, bus_addr, e.addr);
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            #1;
            if (!bus_req) break;
            cyc++;
        end
        n_checks++;
        if (cyc != 4) begin
            n_fail++;
            $display("FAIL to_cycles: got %0d want 4", cyc);
        end
        n_checks++;
        if ({bus_err, stall} !== 2'b10 || rdata !== rd_q[0]) begin
            n_fail++;
            $display("FAIL to_done: got %b %h want 10 %h",
                     {bus_err, stall}, rdata, rd_q[0]);
        end
        void'(rd_q.pop_front());
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus_err, bus_req} !== 2'b0) begin
            n_fail++;
            $display("FAIL to_idle: got %b want 00",
                     {bus_err, bus_req});
        end
    endtask

    task automatic test_ack_vs_timeout();
        bit ok;
        @(negedge clk);
        set_req(1'b1, 1'b0, 3'b100, 4'b0, 32'h501, 32'h0);
        exp_rdata = 32'h55;
        rd_q.push_back(exp_rdata);
        #1;
        wait_req(ok);
        clr_req();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (!ok || bus_req !== 1'b1) begin
            n_fail++;
            $display("FAIL race_req4: got %b %b want 1 1",
                     ok, bus_req);
        end
        bus_ack = 1'b1;
        bus_rdata = 32'h00005500;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        n_checks++;
        if (bus_err !== 1'b0 || rdata !== rd_q[0]) begin
            n_fail++;
            $display("FAIL race_ack: got %b %h want 0 %h",
                     bus_err, rdata, rd_q[0]);
        end
        void'(rd_q.pop_front());
    endtask

    logic [2:0]  b2b_f3  [10] = '{3'b001, 3'b101, 3'b100,
                                  3'b000, 3'b000, 3'b010,
                                  3'b001, 3'b011, 3'b110,
                                  3'b100};
    logic [31:0] b2b_a   [10] = '{32'h402, 32'h402, 32'h401,
                                  32'h401, 32'h400, 32'h400,
                                  32'h400, 32'h400, 32'h404,
                                  32'h403};
    logic [31:0] b2b_exp [10] = '{32'hFFFFF00D, 32'h0000F00D,
                                  32'h0000008A, 32'hFFFFFF8A,
                                  32'h0000007C, 32'hF00D8A7C,
                                  32'hFFFF8A7C, 32'h00000000,
                                  32'h00000000, 32'h000000F0};

    task automatic test_back_to_back();
        bus_exp_t e;
        bit ok;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            set_req(1'b1, 1'b0, b2b_f3[i], 4'b0,
                    b2b_a[i], 32'h0);
            bus_q.push_back('{{b2b_a[i][31:2], 2'b00},
                              1'b0, 4'b0, 32'h0});
            exp_rdata = b2b_exp[i];
            rd_q.push_back(exp_rdata);
            #1;
            n_checks++;
            if (stall !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_stall[%0d]: got %b want 1",
                         i, stall);
            end
            wait_req(ok);
            clr_req();
            e = bus_q.pop_front();
            n_checks++;
            if (!ok || bus_addr !== e.addr || bus_wstrb !== e.wstrb) begin
                n_fail++;
                $display("FAIL b2b_bus[%0d]: got %b %h %b want 1 %h %b",
                         i, ok, bus_addr, bus_wstrb, e.addr, e.wstrb);
            end
            bus_ack = 1'b1;
            bus_rdata = 32'hF00D8A7C;
            @(negedge clk);
            bus_ack = 1'b0;
            #1;
            n_checks++;
            if (rdata !== rd_q[0]) begin
                n_fail++;
                $display("FAIL b2b_rdata[%0d]: got %h want %h",
                         i, rdata, rd_q[0]);
            end
            void'(rd_q.pop_front());
        end
    endtask

    task automatic test_rd_we_both();
        bus_exp_t e;
        bit ok;
        @(negedge clk);
        set_req(1'b1, 1'b1, 3'b010, 4'b1111, 32'h10, 32'hCAFEF00D);
        bus_q.push_back('{32'h10, 1'b1, 4'b1111, 32'hCAFEF00D});
        rd_q.push_back(exp_rdata);
        #1;
        wait_req(ok);
        clr_req();
        e = bus_q.pop_front();
        n_checks++;
        if (!ok || {bus_addr, bus_we, bus_wstrb, bus_wdata} !==
            {e.addr, e.we, e.wstrb, e.wdata}) begin
            n_fail++;
            $display("FAIL both_bus: got %h %b %b %h want %h %b %b %h",
                     bus_addr, bus_we, bus_wstrb, bus_wdata,
                     e.addr, e.we, e.wstrb, e.wdata);
        end
        bus_ack = 1'b1;
        bus_rdata = 32'h11111111;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        n_checks++;
        if (rdata !== rd_q[0]) begin
            n_fail++;
            $display("FAIL both_rdata: got %h want %h",
                     rdata, rd_q[0]);
        end
        void'(rd_q.pop_front());
    endtask

    task automatic test_reset_in_req();
        bit ok;
        @(negedge clk);
        set_req(1'b1, 1'b0, 3'b010, 4'b0, 32'h600, 32'h0);
        #1;
        wait_req(ok);
        clr_req();
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rreq_req: got no bus_req want bus_req");
        end
        @(negedge clk);
        rst = 1'b1;
        exp_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        bus_ack = 1'b1;
        bus_rdata = 32'h12345678;
        #1;
        n_checks++;
        if ({bus_req, stall} !== 2'b0 || rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL rreq_drop: got %b %h want 00 %h",
                     {bus_req, stall}, rdata, exp_rdata);
        end
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        n_checks++;
        if ({bus_req, bus_err} !== 2'b0 || rdata !== exp_rdata) begin
            n_fail++;
            $display("FAIL rreq_stray: got %b %h want 00 %h",
                     {bus_req, bus_err}, rdata, exp_rdata);
        end
        n_checks++;
        if (bus_q.size() != 0 || rd_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_empty: got %0d %0d want 0 0",
                     bus_q.size(), rd_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_lb();
        test_sh();
        test_misalign();
        test_timeout();
        test_ack_vs_timeout();
        test_back_to_back();
        test_rd_we_both();
        test_reset_in_req();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
